// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared aluop codes, LSU state encoding, exception bit positions and decode helpers.
`default_nettype none

package mem_lsu_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam int EXC_ADEL_BIT = 4;
  localparam int EXC_ADES_BIT = 5;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } lsu_state_e;

  function automatic logic is_mem_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_mem_op = 1'b1;
      default:                         is_mem_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_load_op(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load_op = 1'b1;
      default:                                                is_load_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_load(input logic [7:0] op);
    is_signed_load = (op == EXE_LB_OP) || (op == EXE_LH_OP);
  endfunction

  function automatic logic [1:0] op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SZ_HALF;
      default:                          op_size = SZ_WORD;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lsu_lane.sv
// lsu_lane: big-endian byte-lane select, store replication and load extraction (combinational).
`default_nettype none

module lsu_lane
  import mem_lsu_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] ld_word_i,
  output logic [3:0]  sel_o,
  output logic [31:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    case (off_i)
      2'd0:    ld_byte = ld_word_i[31:24];
      2'd1:    ld_byte = ld_word_i[23:16];
      2'd2:    ld_byte = ld_word_i[15:8];
      default: ld_byte = ld_word_i[7:0];
    endcase
    // Half lanes follow addr[1] only; addr[0] is ignored when unchecked.
    ld_half = off_i[1] ? ld_word_i[15:0] : ld_word_i[31:16];
  end

  always_comb begin
    sel_o     = 4'b1111;
    st_data_o = st_data_i;
    ld_data_o = ld_word_i;
    case (size_i)
      SZ_BYTE: begin
        sel_o     = 4'b1000 >> off_i;
        st_data_o = {4{st_data_i[7:0]}};
        ld_data_o = sext_i ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      end
      SZ_HALF: begin
        sel_o     = off_i[1] ? 4'b0011 : 4'b1100;
        st_data_o = {2{st_data_i[15:0]}};
        ld_data_o = sext_i ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with a 4-state bus handshake FSM.
// Optional LSU_ADDR_ERR_EN adds alignment checking with address-error exception bits.
`default_nettype none

module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_excepttype,
  input  logic        flush,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic [31:0] excepttype_o,
  output logic        stallreq
);

  import mem_lsu_pkg::*;

  lsu_state_e  state_q, state_d;
  logic        bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]  bus_sel_q;
  logic [1:0]  size_q, off_q;
  logic        sext_q, load_q;

  logic        is_mem, is_load, addr_err, exc_any;
  logic        issue, capture, stall, wreg;
  logic [31:0] wdata, exc_word;
  logic [1:0]  lane_size, lane_off;
  logic [3:0]  lane_sel;
  logic [31:0] lane_st_data, lane_ld_data;

  assign is_mem  = is_mem_op(mem_aluop);
  assign is_load = is_load_op(mem_aluop);

`ifdef LSU_ADDR_ERR_EN
  assign addr_err = is_mem &&
                    (((op_size(mem_aluop) == SZ_HALF) && mem_mem_addr[0]) ||
                     ((op_size(mem_aluop) == SZ_WORD) && (mem_mem_addr[1:0] != 2'b00)));
  always_comb begin
    exc_word = mem_excepttype;
    if (addr_err) begin
      if (is_load) exc_word[EXC_ADEL_BIT] = 1'b1;
      else         exc_word[EXC_ADES_BIT] = 1'b1;
    end
  end
`else
  assign addr_err = 1'b0;
  assign exc_word = mem_excepttype;
`endif

  assign exc_any = (mem_excepttype != ZERO_WORD) || addr_err;

  // Issue uses the live instruction; DONE extracts with what was latched at issue.
  assign lane_size = (state_q == ST_IDLE) ? op_size(mem_aluop) : size_q;
  assign lane_off  = (state_q == ST_IDLE) ? mem_mem_addr[1:0] : off_q;

  lsu_lane u_lane (
    .size_i    (lane_size),
    .off_i     (lane_off),
    .sext_i    (sext_q),
    .st_data_i (mem_reg2),
    .ld_word_i (rdata_q),
    .sel_o     (lane_sel),
    .st_data_o (lane_st_data),
    .ld_data_o (lane_ld_data)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    capture = 1'b0;
    stall   = 1'b0;
    wreg    = mem_wreg;
    wdata   = mem_wdata;
    case (state_q)
      ST_IDLE: begin
        if (is_mem) begin
          wreg = 1'b0;
          if (!exc_any) begin
            stall = 1'b1;
            if (!flush) begin
              issue   = 1'b1;
              state_d = ST_BUSY;
            end
          end
        end
      end
      ST_BUSY: begin
        wreg  = 1'b0;
        stall = 1'b1;
        if (bus_ack) begin
          capture = !flush;
          state_d = flush ? ST_IDLE : ST_DONE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (load_q) wdata = lane_ld_data;
        else        wreg  = 1'b0;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        wreg = 1'b0;
        if (bus_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= ZERO_WORD;
      bus_sel_q   <= 4'h0;
      bus_wdata_q <= ZERO_WORD;
      rdata_q     <= ZERO_WORD;
      size_q      <= SZ_WORD;
      off_q       <= 2'b00;
      sext_q      <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (issue) begin
        bus_addr_q  <= {mem_mem_addr[31:2], 2'b00};
        bus_sel_q   <= lane_sel;
        bus_wdata_q <= lane_st_data;
        bus_we_q    <= !is_load;
        size_q      <= op_size(mem_aluop);
        off_q       <= mem_mem_addr[1:0];
        sext_q      <= is_signed_load(mem_aluop);
        load_q      <= is_load;
      end
      if (capture) rdata_q <= bus_rdata;
    end
  end

  assign bus_req   = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

  // Combinational outputs are forced low while reset is held, independent of clk.
  assign stallreq     = rst & stall;
  assign wb_wd        = rst ? mem_wd : 5'd0;
  assign wb_wreg      = rst & wreg;
  assign wb_wdata     = rst ? wdata : ZERO_WORD;
  assign excepttype_o = rst ? exc_word : ZERO_WORD;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed self-checking bench for mem_lsu with hand-computed expectations.
`default_nettype none

module tb_mem_lsu;

  localparam logic [7:0] NOP = 8'h00;
  localparam logic [7:0] LB  = 8'hE0;
  localparam logic [7:0] LH  = 8'hE1;
  localparam logic [7:0] LW  = 8'hE3;
  localparam logic [7:0] LBU = 8'hE4;
  localparam logic [7:0] LHU = 8'hE5;
  localparam logic [7:0] SB  = 8'hE8;
  localparam logic [7:0] SH  = 8'hE9;
  localparam logic [7:0] SW  = 8'hEB;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2, mem_wdata, mem_excepttype;
  logic [4:0]  mem_wd;
  logic        mem_wreg, flush;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_sel;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata, excepttype_o;
  logic        stallreq;

  int checks   = 0;
  int failures = 0;

  logic        obs_req, obs_we;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_sel;
  int          lat;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_aluop      (mem_aluop),
    .mem_mem_addr   (mem_mem_addr),
    .mem_reg2       (mem_reg2),
    .mem_wd         (mem_wd),
    .mem_wreg       (mem_wreg),
    .mem_wdata      (mem_wdata),
    .mem_excepttype (mem_excepttype),
    .flush          (flush),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_sel        (bus_sel),
    .bus_wdata      (bus_wdata),
    .bus_ack        (bus_ack),
    .bus_rdata      (bus_rdata),
    .wb_wd          (wb_wd),
    .wb_wreg        (wb_wreg),
    .wb_wdata       (wb_wdata),
    .excepttype_o   (excepttype_o),
    .stallreq       (stallreq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Presents one memory op and runs it to DONE; ack arrives in BUSY cycle ack_at.
  task automatic do_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                        input int ack_at, input logic [31:0] rdata);
    mem_aluop = op; mem_mem_addr = addr; mem_reg2 = reg2;
    mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h5A5A_5A5A;
    lat = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stallreq) break;
      lat++;
      if (c == 1) begin
        obs_req = bus_req; obs_we = bus_we; obs_addr = bus_addr;
        obs_sel = bus_sel; obs_wdata = bus_wdata;
      end
      bus_ack = (c == ack_at);
      bus_rdata = rdata;
      tick;
    end
    bus_ack = 1'b0;
  endtask

  task automatic finish_op;
    mem_aluop = NOP; mem_wreg = 1'b0;
    tick;
  endtask

  initial begin
    rst = 1'b0; mem_aluop = NOP; mem_mem_addr = '0; mem_reg2 = '0;
    mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h5555_5555; mem_excepttype = '0;
    flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #2;
    check("rst_wreg", {31'h0, wb_wreg}, 32'h0);
    check("rst_wdata", wb_wdata, 32'h0);
    check("rst_req", {31'h0, bus_req}, 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    #15 rst = 1'b1;
    tick;

    mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF;
    #1;
    check("pass_wdata", wb_wdata, 32'hDEAD_BEEF);
    check("pass_wd", {27'h0, wb_wd}, 32'd5);
    check("pass_wreg", {31'h0, wb_wreg}, 32'h1);
    check("pass_stall", {31'h0, stallreq}, 32'h0);
    tick;

    do_mem(LW, 32'h100, 32'h0, 3, 32'h1122_3344);
    check("lw_lat", lat, 4);
    check("lw_req", {31'h0, obs_req}, 32'h1);
    check("lw_addr", obs_addr, 32'h100);
    check("lw_sel", {28'h0, obs_sel}, 32'hF);
    check("lw_we", {31'h0, obs_we}, 32'h0);
    check("lw_wreg", {31'h0, wb_wreg}, 32'h1);
    check("lw_data", wb_wdata, 32'h1122_3344);
    check("lw_done_req", {31'h0, bus_req}, 32'h0);
    finish_op;

    do_mem(LB, 32'h103, 32'h0, 1, 32'h0000_00F0);
    check("lb_lat", lat, 2);
    check("lb_sel", {28'h0, obs_sel}, 32'h1);
    check("lb_addr", obs_addr, 32'h100);
    check("lb_data", wb_wdata, 32'hFFFF_FFF0);
    finish_op;
    do_mem(LBU, 32'h103, 32'h0, 1, 32'h0000_00F0);
    check("lbu_data", wb_wdata, 32'h0000_00F0);
    finish_op;
    do_mem(LB, 32'h101, 32'h0, 2, 32'h12AB_5678);
    check("lb1_sel", {28'h0, obs_sel}, 32'h4);
    check("lb1_data", wb_wdata, 32'hFFFF_FFAB);
    finish_op;
    do_mem(LH, 32'h100, 32'h0, 1, 32'h8001_1234);
    check("lh_sel", {28'h0, obs_sel}, 32'hC);
    check("lh_data", wb_wdata, 32'hFFFF_8001);
    finish_op;
    do_mem(LHU, 32'h102, 32'h0, 1, 32'h8001_F234);
    check("lhu_sel", {28'h0, obs_sel}, 32'h3);
    check("lhu_data", wb_wdata, 32'h0000_F234);
    finish_op;

    do_mem(SH, 32'h102, 32'h0000_ABCD, 1, 32'h0);
    check("sh_we", {31'h0, obs_we}, 32'h1);
    check("sh_sel", {28'h0, obs_sel}, 32'h3);
    check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_wreg", {31'h0, wb_wreg}, 32'h0);
    finish_op;
    do_mem(SB, 32'h101, 32'h1234_5678, 1, 32'h0);
    check("sb_sel", {28'h0, obs_sel}, 32'h4);
    check("sb_wdata", obs_wdata, 32'h7878_7878);
    finish_op;
    do_mem(SW, 32'h104, 32'hCAFE_F00D, 2, 32'h0);
    check("sw_addr", obs_addr, 32'h104);
    check("sw_wdata", obs_wdata, 32'hCAFE_F00D);
    finish_op;

    mem_aluop = LW; mem_mem_addr = 32'h180; mem_excepttype = 32'h0000_0200;
    #1;
    check("exc_stall", {31'h0, stallreq}, 32'h0);
    check("exc_pass", excepttype_o, 32'h0000_0200);
    tick;
    check("exc_noreq", {31'h0, bus_req}, 32'h0);
    mem_excepttype = '0; mem_aluop = NOP;
    tick;

    mem_aluop = LW; mem_mem_addr = 32'h200;
    tick;
    flush = 1'b1;
    tick;
    flush = 1'b0; mem_aluop = NOP; mem_wreg = 1'b1; mem_wdata = 32'h0000_0077;
    #1;
    check("drain_req", {31'h0, bus_req}, 32'h1);
    check("drain_stall", {31'h0, stallreq}, 32'h0);
    check("drain_wreg", {31'h0, wb_wreg}, 32'h0);
    tick;
    bus_ack = 1'b1; bus_rdata = 32'hBAAD_F00D;
    #1;
    check("drain_req2", {31'h0, bus_req}, 32'h1);
    tick;
    bus_ack = 1'b0;
    #1;
    check("drain_idle_req", {31'h0, bus_req}, 32'h0);
    check("drain_idle_wreg", {31'h0, wb_wreg}, 32'h1);
    tick;
    do_mem(LW, 32'h300, 32'h0, 1, 32'h0BAD_CAFE);
    check("post_drain_lat", lat, 2);
    check("post_drain_data", wb_wdata, 32'h0BAD_CAFE);
    finish_op;

    mem_aluop = LW; mem_mem_addr = 32'h340;
    tick;
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1357_9BDF;
    tick;
    flush = 1'b0; bus_ack = 1'b0; mem_aluop = NOP; mem_wreg = 1'b1; mem_wdata = 32'h0000_0042;
    #1;
    check("flush_ack_req", {31'h0, bus_req}, 32'h0);
    check("flush_ack_wdata", wb_wdata, 32'h0000_0042);
    tick;

`ifdef LSU_ADDR_ERR_EN
    mem_aluop = LW; mem_mem_addr = 32'h102;
    #1;
    check("ade_exc", excepttype_o, 32'h0000_0010);
    check("ade_stall", {31'h0, stallreq}, 32'h0);
    check("ade_wreg", {31'h0, wb_wreg}, 32'h0);
    tick;
    check("ade_noreq", {31'h0, bus_req}, 32'h0);
    mem_aluop = NOP;
    tick;
`else
    do_mem(LW, 32'h102, 32'h0, 1, 32'h2468_ACE0);
    check("unal_addr", obs_addr, 32'h100);
    check("unal_data", wb_wdata, 32'h2468_ACE0);
    finish_op;
`endif

    mem_aluop = LW; mem_mem_addr = 32'h400; mem_wreg = 1'b1;
    tick;
    #2 rst = 1'b0;
    #1;
    check("rstb_req", {31'h0, bus_req}, 32'h0);
    check("rstb_sel", {28'h0, bus_sel}, 32'h0);
    check("rstb_stall", {31'h0, stallreq}, 32'h0);
    check("rstb_wreg", {31'h0, wb_wreg}, 32'h0);
    mem_aluop = NOP; mem_wdata = 32'h0000_0077;
    #2 rst = 1'b1;
    tick;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    tick;
    bus_ack = 1'b0;
    #1;
    check("stray_ack_wreg", {31'h0, wb_wreg}, 32'h1);
    check("stray_ack_wdata", wb_wdata, 32'h0000_0077);
    check("stray_ack_req", {31'h0, bus_req}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have inputs mem_aluop (Alu_Op), mem_mem_addr (32), mem_reg2 (32, store data), mem_wd (5), mem_wreg (1), mem_wdata (32) and mem_excepttype (32), all from the EX/MEM register.
REQ-004 SHALL have input flush, 1, which kills the in-flight instruction.
REQ-005 SHALL have outputs bus_req (1), bus_we (1), bus_addr (32, word-aligned), bus_sel (4), bus_wdata (32), plus inputs bus_ack (1) and bus_rdata (32): the data-bus handshake.
REQ-006 SHALL have outputs wb_wd (5), wb_wreg (1), wb_wdata (32) and excepttype_o (32), all to the MEM/WB register.
REQ-007 SHALL have output stallreq, 1, the stall request to ctrl that holds stall[4:0].

Function
REQ-008 Non-memory aluop SHALL pass mem_wd, mem_wreg and mem_wdata to wb_* combinationally, with stallreq=0 and no bus activity.
REQ-009 Memory ops SHALL be LB, LBU, LH, LHU, LW, SB, SH and SW, decoded from shared aluop constants.
REQ-010 FSM states SHALL be IDLE, BUSY, DONE and DRAIN.
REQ-011 In IDLE with a memory op, mem_excepttype==0 and flush=0: next state BUSY.
- At the same edge, the FSM SHALL register bus_addr={addr[31:2],2'b00}, bus_sel, bus_wdata and bus_we.
REQ-012 Byte lanes SHALL be big-endian:
- Byte access: off 0/1/2/3 -> sel 1000/0100/0010/0001.
- Half access: off 0 -> sel 1100; off 2 -> sel 0011.
- Word access: sel 1111.
- Store data SHALL be replicated into the selected lanes.
REQ-013 bus_req SHALL be 1 in BUSY and DRAIN only, and the address, sel, wdata and we SHALL stay stable until bus_ack.
REQ-014 In BUSY with bus_ack=1: bus_rdata SHALL be captured into a hold register, and next state DONE.
REQ-015 In DONE:
- stallreq SHALL be 0.
- Loads SHALL drive wb_wdata from the hold register, byte/half-extracted by offset; LB/LH sign-extend, LBU/LHU zero-extend.
- Stores SHALL drive wb_wreg=0.
- Next state IDLE unconditionally.
REQ-016 stallreq SHALL be 1 whenever a memory op is presented and the state is not DONE, including the IDLE cycle it arrives in.
- Minimum load/store latency is 2 cycles with ack in the first BUSY cycle.
REQ-017 flush in IDLE or DONE SHALL go to IDLE.
- flush in BUSY without ack SHALL go to DRAIN.
- DRAIN SHALL hold bus_req until bus_ack, discard data, then go to IDLE.
- stallreq SHALL be 0 and wb_wreg 0 while in DRAIN.
REQ-018 flush in BUSY coincident with bus_ack SHALL go to IDLE with the data discarded.
REQ-019 A memory op with nonzero mem_excepttype SHALL not issue a bus request, SHALL keep stallreq=0, and SHALL pass the exception through.
REQ-020 excepttype_o SHALL equal mem_excepttype, OR'd with the address-error bits of REQ-025 when that feature is compiled in.

Reset
REQ-021 rst low SHALL immediately set the state to IDLE, clear the bus_* outputs and the hold register, and set stallreq=0 and wb_*=0, regardless of clk.
REQ-022 Reset asserted mid-transaction SHALL abandon it; a late bus_ack in IDLE SHALL be ignored.

Configuration
REQ-023 Macro LSU_ADDR_ERR_EN SHALL gate alignment checking.
REQ-024 With LSU_ADDR_ERR_EN undefined, no alignment check SHALL be made and the low address bits SHALL be used as-is per REQ-012.
REQ-025 With LSU_ADDR_ERR_EN defined:
- Half access with addr[0]=1, or word access with addr[1:0]!=0, SHALL raise an address-error bit: bit 4 for loads, bit 5 for stores.
- That access SHALL issue no bus request, keep stallreq=0, and drive wb_wreg=0.

Structure
REQ-026 Aluop codes, the FSM state encoding, the exception bit positions and Zero_Word SHALL live in the shared define package.
REQ-027 The byte-lane select/extract logic SHALL be sub-module lsu_lane, which is purely combinational and shared by the store and load paths.

Verification
REQ-028 LW at 0x100, ack after 3 cycles, rdata 0x11223344 -> stallreq high 4 cycles, then wb_wdata=0x11223344 and wb_wreg=1.
REQ-029 LB at 0x103 with rdata 0x000000F0 -> sel 0001, wb_wdata=0xFFFFFFF0; LBU at the same address -> 0x000000F0.
REQ-030 SH at 0x102 with reg2 0x0000ABCD -> bus_we=1, sel 0011, wdata 0xABCDABCD, wb_wreg=0.
REQ-031 flush during BUSY, ack 2 cycles later -> bus_req held through DRAIN, no writeback, next LW issues normally.
REQ-032 With LSU_ADDR_ERR_EN defined, LW at 0x102 -> no bus_req, excepttype_o bit4=1, stallreq=0.
REQ-033 rst low during BUSY -> all outputs 0 immediately; a stray bus_ack after release produces no writeback.
